// File: rtl/dp_sequencer_pkg.sv
// Shared constants and types for the datapath sequencer: opcodes, one-hot
// ALU operations, FSM states and decoded instruction classes.
package dp_sequencer_pkg;

  localparam logic [5:0] OPC_NOP  = 6'h00;
  localparam logic [5:0] OPC_ALU  = 6'h01;
  localparam logic [5:0] OPC_ADDI = 6'h02;
  localparam logic [5:0] OPC_LDW  = 6'h03;
  localparam logic [5:0] OPC_STW  = 6'h04;

  // One-hot ALU operations; bit position equals the R-type funct code.
  localparam logic [13:0] ALU_ADD   = 14'h0001;
  localparam logic [13:0] ALU_SUB   = 14'h0002;
  localparam logic [13:0] ALU_AND   = 14'h0004;
  localparam logic [13:0] ALU_OR    = 14'h0008;
  localparam logic [13:0] ALU_XOR   = 14'h0010;
  localparam logic [13:0] ALU_NOR   = 14'h0020;
  localparam logic [13:0] ALU_SLL   = 14'h0040;
  localparam logic [13:0] ALU_SRL   = 14'h0080;
  localparam logic [13:0] ALU_SRA   = 14'h0100;
  localparam logic [13:0] ALU_SLT   = 14'h0200;
  localparam logic [13:0] ALU_SLTU  = 14'h0400;
  localparam logic [13:0] ALU_LUI   = 14'h0800;
  localparam logic [13:0] ALU_PASSA = 14'h1000;
  localparam logic [13:0] ALU_PASSB = 14'h2000;

  // Highest funct code that maps to a defined ALU operation.
  localparam logic [3:0] FUNCT_MAX = 4'd13;

  localparam logic [31:0] INSTR_NOP = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_ADDI,
    CLS_LDW,
    CLS_STW,
    CLS_ILL
  } cls_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/dp_sequencer_decoder.sv
// Combinational instruction decoder: splits the instruction word into
// datapath controls and classifies it for the sequencer FSM.
module dp_decoder
  import dp_sequencer_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [13:0] op_o,
  output logic [4:0]  addr_a_o,
  output logic [4:0]  addr_b_o,
  output logic [4:0]  addr_d_o,
  output logic [31:0] immed_o,
  output logic        y_sel_o,
  output cls_e        cls_o,
  output logic        illegal_o
);

  logic [5:0] opc;
  logic [3:0] funct;

  assign opc      = instr_i[31:26];
  assign funct    = instr_i[3:0];
  assign addr_d_o = instr_i[25:21];
  assign addr_a_o = instr_i[20:16];
  assign addr_b_o = instr_i[15:11];
  assign immed_o  = sext16(instr_i[15:0]);

  // Opcode/funct classification and ALU operation selection.
  always_comb begin
    op_o      = '0;
    y_sel_o   = 1'b0;
    cls_o     = CLS_ILL;
    case (opc)
      OPC_NOP:  cls_o = CLS_NOP;
      OPC_ALU: begin
        if (funct <= FUNCT_MAX) begin
          op_o    = ALU_ADD << funct;
          y_sel_o = 1'b1;
          cls_o   = CLS_ALU;
        end
      end
      OPC_ADDI: begin
        op_o  = ALU_ADD;
        cls_o = CLS_ADDI;
      end
      OPC_LDW: begin
        op_o  = ALU_ADD;
        cls_o = CLS_LDW;
      end
      OPC_STW: begin
        op_o  = ALU_ADD;
        cls_o = CLS_STW;
      end
      default: cls_o = CLS_ILL;
    endcase
    illegal_o = (cls_o == CLS_ILL);
  end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle control unit: accepts one instruction from fetch, sequences
// EXEC / MEM / WB and drives the register-file/ALU datapath controls.
module dp_sequencer
  import dp_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [13:0] dp_op,
  output logic [4:0]  dp_addr_a,
  output logic [4:0]  dp_addr_b,
  output logic [4:0]  dp_addr_d,
  output logic [31:0] dp_immed,
  output logic        dp_y_sel,
  output logic        dp_write,
  output logic        dp_wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;

  cls_e dec_cls;
  logic dec_illegal;

  dp_decoder u_dec (
    .instr_i   (instr_q),
    .op_o      (dp_op),
    .addr_a_o  (dp_addr_a),
    .addr_b_o  (dp_addr_b),
    .addr_d_o  (dp_addr_d),
    .immed_o   (dp_immed),
    .y_sel_o   (dp_y_sel),
    .cls_o     (dec_cls),
    .illegal_o (dec_illegal)
  );

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;

  // State, latched instruction, timeout counter and registered error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      instr_q <= INSTR_NOP;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and per-state memory/writeback controls.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    tcnt_d    = tcnt_q;
    err_d     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    dp_write  = 1'b0;
    dp_wb_sel = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        tcnt_d = '0;
        if (dec_illegal) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          case (dec_cls)
            CLS_ALU, CLS_ADDI: state_d = ST_WB;
            CLS_LDW, CLS_STW:  state_d = ST_MEM;
            default:           state_d = ST_IDLE;
          endcase
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (dec_cls == CLS_STW);
        if (mem_ack) begin
          tcnt_d  = '0;
          state_d = (dec_cls == CLS_LDW) ? ST_WB : ST_IDLE;
        end else if ((MEM_TIMEOUT != 0) && (tcnt_q == TO_LAST)) begin
          tcnt_d  = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + CW'(1);
        end
      end
      ST_WB: begin
        // r0 is hard-wired: the WB cycle still happens, only the strobe is masked.
        dp_write  = (dp_addr_d != 5'd0);
        dp_wb_sel = (dec_cls == CLS_LDW);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer with a small register-file/ALU and
// memory model around the DUT; expected writebacks go through a scoreboard.
module tb_dp_sequencer;
  import dp_sequencer_pkg::*;

  localparam int TO = 8;
  localparam logic [31:0] RDATA = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [13:0] dp_op;
  logic [4:0]  dp_addr_a, dp_addr_b, dp_addr_d;
  logic [31:0] dp_immed;
  logic        dp_y_sel, dp_write, dp_wb_sel;
  logic        mem_req, mem_we;
  logic        mem_ack = 1'b0;
  logic        busy, err;

  always #5 clk = ~clk;

  dp_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .dp_op       (dp_op),
    .dp_addr_a   (dp_addr_a),
    .dp_addr_b   (dp_addr_b),
    .dp_addr_d   (dp_addr_d),
    .dp_immed    (dp_immed),
    .dp_y_sel    (dp_y_sel),
    .dp_write    (dp_write),
    .dp_wb_sel   (dp_wb_sel),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .busy        (busy),
    .err         (err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wb_sel;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] regs [32];
  int          ack_wait = -1;
  logic        stray_ack = 1'b0;
  int          req_cyc = 0, last_burst = 0, err_cnt = 0, wr_cnt = 0;
  logic [31:0] exp_mem_addr = '0;
  logic        exp_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] alu(input logic [13:0] op, input logic [31:0] a, input logic [31:0] y);
    case (op)
      ALU_ADD: return a + y;
      ALU_SUB: return a - y;
      ALU_AND: return a & y;
      ALU_OR:  return a | y;
      ALU_XOR: return a ^ y;
      default: return 32'hBAD0BAD0;
    endcase
  endfunction

  function automatic logic [31:0] mk_r(input logic [5:0] opc, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb,
                                       input logic [3:0] funct);
    return {opc, rd, ra, rb, 7'd0, funct};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] opc, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [15:0] imm);
    return {opc, rd, ra, imm};
  endfunction

  // Datapath + memory model: sampled on the falling edge.
  always @(negedge clk) begin : model
    logic [31:0] a, y, res;
    wr_t e;
    a = regs[dp_addr_a];
    y = dp_y_sel ? regs[dp_addr_b] : dp_immed;
    if (err === 1'b1) err_cnt++;
    if (mem_req === 1'b1) begin
      req_cyc++;
      check("mem_addr", a + y, exp_mem_addr);
      check("mem_we", mem_we, exp_we);
      mem_ack = (ack_wait >= 0) && (req_cyc == ack_wait + 1);
    end else begin
      if (req_cyc != 0) last_burst = req_cyc;
      req_cyc = 0;
      mem_ack = stray_ack;
    end
    if (dp_write === 1'b1) begin
      wr_cnt++;
      res = dp_wb_sel ? RDATA : alu(dp_op, a, y);
      check("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr_d", dp_addr_d, e.rd);
        check("wr_data", res, e.data);
        check("wr_wb_sel", dp_wb_sel, e.wb_sel);
      end
      regs[dp_addr_d] = res;
    end
  end

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] w);
    int n = 0;
    instr = w;
    instr_valid = 1'b1;
    while (instr_ready !== 1'b1 && n < 50) begin settle(); n++; end
    check("issue_ready", n < 50, 1);
    settle();
    instr_valid = 1'b0;
    instr = $urandom;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin settle(); n++; end
    check("idle_reached", busy, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int e0, w0;
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[1] = 32'd5;
    regs[2] = 32'd7;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_ctrl", {dp_op, dp_y_sel, dp_wb_sel, dp_write, mem_req, mem_we, busy, err}, 0);
    check("rst_immed", dp_immed, 0);
    check("rst_addr", {dp_addr_a, dp_addr_b, dp_addr_d}, 0);
    settle();
    reset = 1'b0;
    settle();

    // ALU add r3 = r1 + r2
    w0 = wr_cnt;
    exp_q.push_back('{5'd3, 32'd12, 1'b0});
    issue(mk_r(OPC_ALU, 5'd3, 5'd1, 5'd2, 4'd0));
    @(negedge clk);
    check("alu_exec_nowrite", dp_write, 0);
    check("alu_y_sel", dp_y_sel, 1);
    check("alu_op", dp_op, ALU_ADD);
    @(negedge clk);
    check("alu_wb_write", dp_write, 1);
    check("alu_wb_addr_d", dp_addr_d, 3);
    wait_idle(10);
    settle();
    check("alu_write_count", wr_cnt - w0, 1);

    // ADDI r4 = r1 + (-2)
    exp_q.push_back('{5'd4, 32'd3, 1'b0});
    issue(mk_i(OPC_ADDI, 5'd4, 5'd1, 16'hFFFE));
    @(negedge clk);
    check("addi_immed", dp_immed, 32'hFFFFFFFE);
    check("addi_y_sel", dp_y_sel, 0);
    wait_idle(10);
    settle();

    // LDW r5 = mem[r1 + 4], ack after 3 wait cycles
    regs[1] = 32'h100;
    exp_mem_addr = 32'h104;
    exp_we = 1'b0;
    ack_wait = 3;
    exp_q.push_back('{5'd5, RDATA, 1'b1});
    issue(mk_i(OPC_LDW, 5'd5, 5'd1, 16'h0004));
    wait_idle(40);
    settle();
    check("ldw_req_cycles", last_burst, 4);

    // STW with no ack: times out
    e0 = err_cnt; w0 = wr_cnt;
    exp_mem_addr = 32'h100 + 32'h1008;
    exp_we = 1'b1;
    ack_wait = -1;
    issue(mk_i(OPC_STW, 5'd0, 5'd1, {5'd2, 11'h008}));
    wait_idle(40);
    @(negedge clk);
    check("to_ready_after", instr_ready, 1);
    check("to_err_pulse", err, 1);
    check("to_req_dropped", mem_req, 0);
    settle(); settle();
    check("to_req_cycles", last_burst, TO);
    check("to_err_count", err_cnt - e0, 1);
    check("to_no_write", wr_cnt - w0, 0);

    // Illegal opcode 0x3F
    e0 = err_cnt; w0 = wr_cnt;
    issue(mk_i(6'h3F, 5'd7, 5'd1, 16'h1234));
    wait_idle(10);
    settle(); settle();
    check("ill_opc_err", err_cnt - e0, 1);
    check("ill_opc_nowrite", wr_cnt - w0, 0);

    // Illegal funct (above highest ALU op)
    e0 = err_cnt; w0 = wr_cnt;
    issue(mk_r(OPC_ALU, 5'd7, 5'd1, 5'd2, 4'hF));
    wait_idle(10);
    settle(); settle();
    check("ill_funct_err", err_cnt - e0, 1);
    check("ill_funct_nowrite", wr_cnt - w0, 0);

    // ALU with rd = r0: full path through WB, write masked
    e0 = err_cnt; w0 = wr_cnt;
    issue(mk_r(OPC_ALU, 5'd0, 5'd1, 5'd2, 4'd1));
    @(negedge clk);
    check("r0_exec_busy", busy, 1);
    @(negedge clk);
    check("r0_wb_busy", busy, 1);
    check("r0_wb_nowrite", dp_write, 0);
    @(negedge clk);
    check("r0_idle", busy, 0);
    settle();
    check("r0_write_count", wr_cnt - w0, 0);
    check("r0_no_err", err_cnt - e0, 0);

    // Reset while LDW waits in MEM
    e0 = err_cnt; w0 = wr_cnt;
    exp_mem_addr = 32'h104;
    exp_we = 1'b0;
    ack_wait = -1;
    issue(mk_i(OPC_LDW, 5'd6, 5'd1, 16'h0004));
    @(negedge clk);
    @(negedge clk);
    check("rstm_in_mem", mem_req, 1);
    settle(); settle();
    reset = 1'b1;
    settle();
    reset = 1'b0;
    @(negedge clk);
    check("rstm_req", mem_req, 0);
    check("rstm_busy", busy, 0);
    check("rstm_ready", instr_ready, 1);
    stray_ack = 1'b1;
    repeat (5) settle();
    stray_ack = 1'b0;
    settle();
    check("rstm_no_write", wr_cnt - w0, 0);
    check("rstm_no_err", err_cnt - e0, 0);

    // LDW after reset, ack in the first MEM cycle
    ack_wait = 0;
    exp_q.push_back('{5'd6, RDATA, 1'b1});
    issue(mk_i(OPC_LDW, 5'd6, 5'd1, 16'h0004));
    wait_idle(20);
    settle();
    check("ldw0_req_cycles", last_burst, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Multi-cycle control unit that sequences the register-file/ALU datapath.
- Accepts one 32-bit instruction at a time from fetch via a valid/ready handshake, decodes it, and drives the datapath controls: ALU op, register addresses, immediate, y-mux select and write enable.
- Runs load/store through a req/ack data-memory handshake before writeback.
- Sits between the fetch stage and the datapath; it is the only block that asserts the register write enable.

Parameters:
- MEM_TIMEOUT, 255, cycles waited for mem_ack before aborting with err; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  fetch presents an instruction
- instr  in  32  instruction word: [31:26] opc, [25:21] rd, [20:16] ra, [15:11] rb, [15:0] imm16
- instr_ready  out  1  sequencer can accept an instruction
- dp_op  out  14  one-hot ALU operation
- dp_addr_a  out  5  source register a
- dp_addr_b  out  5  source register b
- dp_addr_d  out  5  destination register
- dp_immed  out  32  sign-extended imm16
- dp_y_sel  out  1  1 = ALU y operand from reg b; 0 = from immediate
- dp_write  out  1  register-file write enable, one cycle per instruction
- dp_wb_sel  out  1  0 = write ALU result; 1 = write mem_rdata
- mem_req  out  1  data-memory request; address is the datapath ALU output
- mem_we  out  1  1 = store (data is datapath b_out); 0 = load
- mem_ack  in  1  memory completed the request
- busy  out  1  high whenever state != IDLE
- err  out  1  one-cycle pulse on illegal opcode or memory timeout

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs are 0 except instr_ready=1. Timeout counter=0. The latched instruction is cleared to the NOP encoding.
- Reset mid-operation: any state, including MEM with mem_req high, returns to IDLE on the next edge. mem_req drops in that same cycle. No dp_write occurs.
- Instruction latch: the instruction is latched only when instr_valid && instr_ready. instr_ready=1 only in IDLE.
- Control stability: dp_op, dp_addr_*, dp_immed and dp_y_sel are driven from the latched instruction and stay stable from EXEC through WB.
- Opcode classes (opc):
  - 0x00 NOP
  - 0x01 R-type ALU: dp_op from funct = imm16[3:0] mapped to one-hot; y_sel=1
  - 0x02 ADDI: y_sel=0
  - 0x03 LDW: dp_op=ADD, y_sel=0
  - 0x04 STW: dp_op=ADD, y_sel=0; rb is the store-data register
  - anything else: illegal
- FSM states and transitions:
  - IDLE -> EXEC on handshake.
  - EXEC (1 cycle, ALU settles):
    - NOP -> IDLE with no write.
    - ALU and ADDI -> WB.
    - LDW and STW -> MEM.
    - Illegal opcode -> IDLE with err=1 and no write.
  - MEM: mem_req=1 and mem_we=(STW). Address and data stay stable until mem_ack.
    - On mem_ack: STW -> IDLE; LDW -> WB with dp_wb_sel=1.
    - The timeout counter increments each MEM cycle without ack. On reaching MEM_TIMEOUT: mem_req drops, err=1, -> IDLE, no write.
  - WB: dp_write=1 for exactly one cycle -> IDLE.
- Destination r0: if rd==0, dp_write is suppressed; the FSM path and cycle count are unchanged.
- Latency from handshake to dp_write:
  - ALU/ADDI: 2 cycles (EXEC, WB).
  - LDW: 3 + wait cycles.
  - Back-to-back throughput: ALU/ADDI one instruction every 3 cycles, since IDLE takes one cycle.
- Immediate: dp_immed = {{16{imm16[15]}}, imm16}.
- Funct mapping: funct values above the highest defined ALU op are illegal (err pulse, no write).
- mem_ack outside MEM is ignored.
- An instr_valid that drops before the handshake is not an error.

Decomposition:
- Shared package (CONSTANTS.vh, alongside X32):
  - opcode values OPC_NOP/ALU/ADDI/LDW/STW
  - 14-bit one-hot ALU op constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ...
  - FSM state encodings
- One sub-module, dp_decoder: combinational instr -> {dp_op, addr fields, immed, y_sel, class, illegal}.
- The FSM and timeout counter live in dp_sequencer.

Test Plan:
- ALU add: r1=5, r2=7; instr opc=0x01, rd=3, ra=1, rb=2, funct=ADD -> EXEC then WB. dp_write pulses exactly once at handshake+2 with addr_d=3 and y_sel=1; r3 reads 12.
- ADDI with negative immediate: r1=5, rd=4, imm16=0xFFFE -> dp_immed=0xFFFFFFFE; r4=3 after WB.
- LDW with wait: r1=0x100, imm=4, mem_ack after 3 cycles with rdata 0xDEADBEEF -> mem_req high for 4 cycles. Address 0x104 stays stable; WB has wb_sel=1; reg reads 0xDEADBEEF.
- STW then timeout: MEM_TIMEOUT=8, ack never comes -> mem_req drops after 8 cycles. err pulses once; no dp_write; instr_ready=1 on the next cycle.
- Illegal opcode 0x3F, plus an ALU op with rd=0 -> err pulse and no write for the first. For the second, the FSM goes through WB but dp_write stays 0.
- Reset in MEM during LDW -> next cycle: IDLE, mem_req=0, busy=0, instr_ready=1. Any mem_ack arriving later causes no write.
